// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter for the RAM data port, with read-return routing.
// Grant is combinational (0 cycles); read data returns 1 cycle after grant; a losing requester holds req until granted.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 15,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic                  r0_we,
    input  logic [3:0]            r0_be,
    input  logic [31:0]           r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [31:0]           r0_rdata,
    input  logic                  r1_req,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic                  r1_we,
    input  logic [3:0]            r1_be,
    input  logic [31:0]           r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [31:0]           r1_rdata,
    output logic [ADDR_WIDTH-1:0] d_addr,
    output logic                  d_we,
    output logic [3:0]            d_be,
    output logic [31:0]           d_wdata,
    input  logic [31:0]           d_rdata,
    output logic [CNT_WIDTH-1:0]  r0_gnt_cnt,
    output logic [CNT_WIDTH-1:0]  r1_gnt_cnt
);

    logic                 last_gnt_q, last_gnt_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 rd_owner_q, rd_owner_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (!reset) begin
            // On a tie the requester that did not win last time goes first.
            if (r0_req && r1_req) begin
                r0_gnt = last_gnt_q;
                r1_gnt = !last_gnt_q;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    always_comb begin
        d_addr  = '0;
        d_we    = 1'b0;
        d_be    = 4'b0000;
        d_wdata = 32'h0;
        if (r0_gnt) begin
            d_addr  = r0_addr;
            d_we    = r0_we;
            d_be    = r0_be;
            d_wdata = r0_wdata;
        end else if (r1_gnt) begin
            d_addr  = r1_addr;
            d_we    = r1_we;
            d_be    = r1_be;
            d_wdata = r1_wdata;
        end
    end

    always_comb begin
        last_gnt_d   = last_gnt_q;
        rd_owner_d   = rd_owner_q;
        rd_pending_d = (r0_gnt && !r0_we) || (r1_gnt && !r1_we);
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (r0_gnt) begin
            last_gnt_d = 1'b0;
            rd_owner_d = 1'b0;
            cnt0_d     = cnt0_q + CNT_WIDTH'(1);
        end else if (r1_gnt) begin
            last_gnt_d = 1'b1;
            rd_owner_d = 1'b1;
            cnt1_d     = cnt1_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q   <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    // Gating with reset drops a read whose return cycle coincides with reset.
    assign r0_rvalid  = rd_pending_q && !rd_owner_q && !reset;
    assign r1_rvalid  = rd_pending_q && rd_owner_q && !reset;
    assign r0_rdata   = r0_rvalid ? d_rdata : 32'h0;
    assign r1_rdata   = r1_rvalid ? d_rdata : 32'h0;
    assign r0_gnt_cnt = cnt0_q;
    assign r1_gnt_cnt = cnt1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: RAM model on the data port, reference memory and read-return scoreboard.
module tb_dmem_port_arbiter;

    localparam int AW = 15;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [3:0]    r0_be;
    logic [31:0]   r0_wdata, r0_rdata;
    logic          r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [3:0]    r1_be;
    logic [31:0]   r1_wdata, r1_rdata;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_wdata;
    logic [31:0]   d_rdata;
    logic [CW-1:0] r0_gnt_cnt, r1_gnt_cnt;

    int n_chk = 0;
    int n_err = 0;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_we(r0_we), .r0_be(r0_be), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_we(r1_we), .r1_be(r1_be), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .r0_gnt_cnt(r0_gnt_cnt), .r1_gnt_cnt(r1_gnt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // RAM model driven only by the DUT's data port (read-first, 1-cycle latency).
    logic [31:0] ram [0:255];
    initial for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    always @(posedge clk) begin
        d_rdata <= ram[d_addr[7:0]];
        if (d_we)
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ram[d_addr[7:0]][8*b +: 8] <= d_wdata[8*b +: 8];
    end

    // Reference model built from the stimulus side.
    typedef struct {
        logic        owner;
        logic [31:0] data;
    } rd_t;
    rd_t         sb[$];
    logic [31:0] ref_mem [0:255];
    logic        m_last = 1'b1;
    logic [CW-1:0] m_cnt0 = '0;
    logic [CW-1:0] m_cnt1 = '0;
    initial for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    always @(negedge clk) begin
        rd_t           e;
        logic          ev0, ev1, eg0, eg1, ewe, w;
        logic [31:0]   ed0, ed1, ewd;
        logic [AW-1:0] ea;
        logic [3:0]    ebe;
        ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!reset) begin
                ev0 = !e.owner; ev1 = e.owner;
                if (e.owner) ed1 = e.data; else ed0 = e.data;
            end
        end
        chk("r0_rvalid", 32'(r0_rvalid), 32'(ev0));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(ev1));
        chk("r0_rdata", r0_rdata, ed0);
        chk("r1_rdata", r1_rdata, ed1);
        chk("rvalid_excl", 32'(r0_rvalid & r1_rvalid), 32'h0);
        chk("r0_gnt_cnt", 32'(r0_gnt_cnt), 32'(m_cnt0));
        chk("r1_gnt_cnt", 32'(r1_gnt_cnt), 32'(m_cnt1));

        eg0 = 1'b0; eg1 = 1'b0;
        if (!reset) begin
            if (r0_req && r1_req) begin
                eg0 = m_last; eg1 = !m_last;
            end else begin
                eg0 = r0_req; eg1 = r1_req;
            end
        end
        chk("r0_gnt", 32'(r0_gnt), 32'(eg0));
        chk("r1_gnt", 32'(r1_gnt), 32'(eg1));

        ea = '0; ewe = 1'b0; ebe = 4'h0; ewd = 32'h0;
        if (eg0) begin ea = r0_addr; ewe = r0_we; ebe = r0_be; ewd = r0_wdata; end
        if (eg1) begin ea = r1_addr; ewe = r1_we; ebe = r1_be; ewd = r1_wdata; end
        chk("d_addr", 32'(d_addr), 32'(ea));
        chk("d_we", 32'(d_we), 32'(ewe));
        chk("d_be", 32'(d_be), 32'(ebe));
        chk("d_wdata", d_wdata, ewd);

        if (eg0 || eg1) begin
            w = eg1;
            m_last = w;
            if (w) m_cnt1 = m_cnt1 + 1'b1; else m_cnt0 = m_cnt0 + 1'b1;
            if (!ewe) sb.push_back('{owner: w, data: ref_mem[ea[7:0]]});
            else
                for (int b = 0; b < 4; b++)
                    if (ebe[b]) ref_mem[ea[7:0]][8*b +: 8] = ewd[8*b +: 8];
        end
        if (reset) begin
            m_last = 1'b1; m_cnt0 = '0; m_cnt1 = '0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        r0_req = req; r0_we = we; r0_addr = a; r0_be = be; r0_wdata = wd;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
        r1_req = req; r1_we = we; r1_addr = a; r1_be = be; r1_wdata = wd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv0(0, 0, '0, 4'h0, 32'h0);
        drv1(0, 0, '0, 4'h0, 32'h0);
        cyc(); cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drv0(0, 0, '0, 4'h0, 32'h0);
        drv1(0, 0, '0, 4'h0, 32'h0);
        do_reset();
        chk("rst_cnt0", 32'(r0_gnt_cnt), 32'h0);
        chk("rst_cnt1", 32'(r1_gnt_cnt), 32'h0);

        // r0 write then read back
        drv0(1, 1, 15'h0010, 4'hF, 32'hDEADBEEF);
        @(negedge clk); chk("t1_wr_gnt", 32'(r0_gnt), 32'h1);
        cyc();
        drv0(1, 0, 15'h0010, 4'hF, 32'h0);
        cyc();
        drv0(0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t1_rvalid", 32'(r0_rvalid), 32'h1);
        chk("t1_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_r1_rvalid", 32'(r1_rvalid), 32'h0);
        chk("t1_cnt0", 32'(r0_gnt_cnt), 32'h2);
        cyc();

        // continuous contention alternates
        do_reset();
        drv0(1, 0, 15'h0020, 4'h0, 32'h0);
        drv1(1, 0, 15'h0021, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_alt", 32'(r1_gnt), 32'(i % 2));
            cyc();
        end
        drv0(0, 0, '0, 4'h0, 32'h0);
        drv1(0, 0, '0, 4'h0, 32'h0);
        chk("t2_cnt0", 32'(r0_gnt_cnt), 32'h3);
        chk("t2_cnt1", 32'(r1_gnt_cnt), 32'h3);
        cyc();

        // interleaved reads to distinct owners
        drv1(1, 1, 15'h0001, 4'hF, 32'h11111111); cyc();
        drv1(1, 1, 15'h0002, 4'hF, 32'h22222222); cyc();
        do_reset();
        drv0(1, 0, 15'h0001, 4'h0, 32'h0);
        drv1(1, 0, 15'h0002, 4'h0, 32'h0);
        cyc();
        drv0(0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t3_r0_rvalid", 32'(r0_rvalid), 32'h1);
        chk("t3_r0_rdata", r0_rdata, 32'h11111111);
        cyc();
        drv1(0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t3_r1_rvalid", 32'(r1_rvalid), 32'h1);
        chk("t3_r1_rdata", r1_rdata, 32'h22222222);
        cyc();

        // byte-enable merge
        drv1(1, 1, 15'h0030, 4'hF, 32'h0); cyc();
        drv1(1, 1, 15'h0030, 4'b0101, 32'hAABBCCDD); cyc();
        drv1(0, 0, '0, 4'h0, 32'h0);
        drv0(1, 0, 15'h0030, 4'h0, 32'h0); cyc();
        drv0(0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t4_rdata", r0_rdata, 32'h00BB00DD);
        cyc();

        // reset in the return cycle drops the read
        drv0(1, 0, 15'h0010, 4'h0, 32'h0); cyc();
        reset = 1'b1;
        drv0(0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5_rvalid", 32'(r0_rvalid), 32'h0);
        chk("t5_gnt_rst", 32'(r0_gnt | r1_gnt), 32'h0);
        cyc();
        reset = 1'b0;
        chk("t5_cnt0", 32'(r0_gnt_cnt), 32'h0);
        drv0(1, 0, 15'h0003, 4'h0, 32'h0);
        drv1(1, 0, 15'h0004, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5_first", 32'({r1_gnt, r0_gnt}), 32'h1);
        cyc();
        drv0(0, 0, '0, 4'h0, 32'h0);
        drv1(0, 0, '0, 4'h0, 32'h0);
        cyc();

        // counter wrap and idle port
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drv1(1, 1, 15'h0040, 4'hF, 32'(i));
            cyc();
        end
        drv1(0, 0, '0, 4'h0, 32'h0);
        chk("t6_wrap", 32'(r1_gnt_cnt), 32'h1);
        @(negedge clk);
        chk("t6_idle_we", 32'(d_we), 32'h0);
        chk("t6_idle_be", 32'(d_be), 32'h0);
        drv0(1, 0, 15'h0040, 4'h0, 32'h0); cyc();
        drv0(0, 0, '0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6_readback", r0_rdata, 32'h10);
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
